// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// the handshake state type and helpers that turn funct3 size bits into masks.
package lsu_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   // funct3 bit that selects zero extension on loads
   localparam int F3_UNSIGNED_BIT = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RSP
   } lsuState_t;

   // Byte-enable pattern for an access of 1<<sizeSel bytes at lane 0
   function automatic logic [7:0] sizeMask(input logic [1:0] sizeSel);
      case (sizeSel)
         2'd0:    sizeMask = 8'h01;
         2'd1:    sizeMask = 8'h03;
         2'd2:    sizeMask = 8'h0F;
         default: sizeMask = 8'hFF;
      endcase
   endfunction

   // Low address bits that must be zero for an access of 1<<sizeSel bytes
   function automatic logic [2:0] offsetMask(input logic [1:0] sizeSel);
      case (sizeSel)
         2'd0:    offsetMask = 3'd0;
         2'd1:    offsetMask = 3'd1;
         2'd2:    offsetMask = 3'd3;
         default: offsetMask = 3'd7;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// Load data alignment: moves the addressed bytes of a full memory word down
// to bit 0 and sign- or zero-extends them to the datapath width.
module lsu_load_extend
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int LANE_W = 2
) (
   input  logic [XLEN-1:0]   rdata,
   input  logic [LANE_W-1:0] lane,
   input  logic [2:0]        funct3,
   output logic [XLEN-1:0]   loadData
);

   logic [XLEN-1:0] shifted;
   logic            zeroExt;

   // Shift the selected lane down, then extend according to the access size;
   // the size casts carry the sign of their operand into the upper bits
   always_comb begin
      shifted  = rdata >> {lane, 3'b000};
      zeroExt  = funct3[F3_UNSIGNED_BIT];
      loadData = shifted;
      case (funct3[1:0])
         2'd0: begin
            if (zeroExt) loadData = XLEN'(shifted[7:0]);
            else         loadData = XLEN'($signed(shifted[7:0]));
         end
         2'd1: begin
            if (zeroExt) loadData = XLEN'(shifted[15:0]);
            else         loadData = XLEN'($signed(shifted[15:0]));
         end
         2'd2: begin
            if (zeroExt) loadData = XLEN'(shifted[31:0]);
            else         loadData = XLEN'($signed(shifted[31:0]));
         end
         default: loadData = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage of the RV32I/RV64I pipeline: formats loads and stores, runs the
// req/gnt/rvalid data-memory handshake (stalling upstream while it waits),
// traps misaligned or illegal accesses and holds the MEM/WB pipeline register.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m_valid,
   input  logic [XLEN-1:0]   m_alu_result,
   input  logic [XLEN-1:0]   m_write_data,
   input  logic [REG_AW-1:0] m_rd,
   input  logic [2:0]        m_funct3,
   input  logic              m_mem_read,
   input  logic              m_mem_write,
   input  logic              m_reg_write,
   input  logic              m_result_src,
   output logic              m_ready,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN/8-1:0] dmem_be,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic [REG_AW-1:0] wb_rd,
   output logic [XLEN-1:0]   wb_result,
   output logic              wb_exc
);

   localparam int NBYTES = XLEN / 8;
   localparam int LANE_W = $clog2(NBYTES);

   lsuState_t state;
   lsuState_t stateNext;

   logic [XLEN-1:0]   addrLatch;
   logic [NBYTES-1:0] beLatch;
   logic [XLEN-1:0]   wdataLatch;
   logic              weLatch;
   logic [2:0]        funct3Latch;
   logic [LANE_W-1:0] laneLatch;

   logic              isMemOp;
   logic              isStore;
   logic              illegalF3;
   logic              misaligned;
   logic              accessFault;
   logic [LANE_W-1:0] reqLane;
   logic [XLEN-1:0]   reqAddr;
   logic [NBYTES-1:0] reqBe;
   logic [XLEN-1:0]   reqWdata;
   logic [XLEN-1:0]   loadData;
   logic              complete;
   logic              excNow;
   logic              latchReq;

   // Classify the instruction in MEM and build the bus request it would issue:
   // word-aligned address, shifted byte enables and store data replicated
   // across every lane so the memory can pick whichever lanes are enabled
   always_comb begin
      isMemOp     = m_valid && (m_mem_read || m_mem_write);
      isStore     = m_mem_write;
      illegalF3   = (m_funct3 == 3'b111) ||
                    ((XLEN == 32) && ((m_funct3 == LD) || (m_funct3 == LWU)));
      reqLane     = m_alu_result[LANE_W-1:0];
      misaligned  = (reqLane & LANE_W'(offsetMask(m_funct3[1:0]))) != '0;
      accessFault = isMemOp && (illegalF3 || misaligned);
      reqAddr     = {m_alu_result[XLEN-1:LANE_W], {LANE_W{1'b0}}};
      reqBe       = NBYTES'(sizeMask(m_funct3[1:0])) << reqLane;
      reqWdata    = m_write_data;
      case (m_funct3[1:0])
         2'd0: for (int i = 0; i < NBYTES; i++)     reqWdata[i*8 +: 8]   = m_write_data[7:0];
         2'd1: for (int i = 0; i < NBYTES / 2; i++) reqWdata[i*16 +: 16] = m_write_data[15:0];
         2'd2: for (int i = 0; i < NBYTES / 4; i++) reqWdata[i*32 +: 32] = m_write_data[31:0];
         default: reqWdata = m_write_data;
      endcase
   end

   // Handshake sequencing: a fresh request is driven straight from the MEM
   // inputs in IDLE and from the captured copy while waiting for the grant.
   // complete marks the cycle the MEM instruction retires into WB.
   always_comb begin
      stateNext  = state;
      m_ready    = 1'b0;
      complete   = 1'b0;
      excNow     = 1'b0;
      latchReq   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_be    = '0;
      dmem_wdata = '0;
      case (state)
         IDLE: begin
            m_ready = 1'b1;
            if (m_valid) begin
               if (isMemOp && !accessFault) begin
                  dmem_req   = 1'b1;
                  dmem_we    = isStore;
                  dmem_addr  = reqAddr;
                  dmem_be    = reqBe;
                  dmem_wdata = reqWdata;
                  latchReq   = 1'b1;
                  if (dmem_gnt) begin
                     if (isStore) begin
                        complete = 1'b1;
                     end else begin
                        m_ready   = 1'b0;
                        stateNext = WAIT_RSP;
                     end
                  end else begin
                     m_ready   = 1'b0;
                     stateNext = WAIT_GNT;
                  end
               end else begin
                  complete = 1'b1;
                  excNow   = accessFault;
               end
            end
         end
         WAIT_GNT: begin
            dmem_req   = 1'b1;
            dmem_we    = weLatch;
            dmem_addr  = addrLatch;
            dmem_be    = beLatch;
            dmem_wdata = wdataLatch;
            if (dmem_gnt) begin
               if (weLatch) begin
                  m_ready   = 1'b1;
                  complete  = 1'b1;
                  stateNext = IDLE;
               end else begin
                  stateNext = WAIT_RSP;
               end
            end
         end
         WAIT_RSP: begin
            if (dmem_rvalid) begin
               m_ready   = 1'b1;
               complete  = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
      if (rst) begin
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
      end
   end

   lsu_load_extend #(
      .XLEN   (XLEN),
      .LANE_W (LANE_W)
   ) loadExtend (
      .rdata    (dmem_rdata),
      .lane     (laneLatch),
      .funct3   (funct3Latch),
      .loadData (loadData)
   );

   // Capture the request when it is first issued so the bus stays stable
   // while the memory withholds the grant and the load response can be aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         addrLatch   <= '0;
         beLatch     <= '0;
         wdataLatch  <= '0;
         weLatch     <= 1'b0;
         funct3Latch <= '0;
         laneLatch   <= '0;
      end else if (latchReq) begin
         addrLatch   <= reqAddr;
         beLatch     <= reqBe;
         wdataLatch  <= reqWdata;
         weLatch     <= isStore;
         funct3Latch <= m_funct3;
         laneLatch   <= reqLane;
      end
   end

   // State register plus MEM/WB register: wb_valid pulses once per retired
   // instruction and the payload holds its last value through bubbles.
   // A trapped access reports its address and never writes the register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_result    <= '0;
         wb_exc       <= 1'b0;
      end else begin
         state    <= stateNext;
         wb_valid <= complete;
         if (complete) begin
            wb_reg_write <= m_reg_write && !excNow;
            wb_rd        <= m_rd;
            wb_exc       <= excNow;
            if (excNow)            wb_result <= m_alu_result;
            else if (m_result_src) wb_result <= loadData;
            else                   wb_result <= m_alu_result;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (XLEN=32): directed cases for the
// documented corner cases followed by randomized instructions, all checked
// against an arithmetic reference model of the load/store rules.
module tb_mem_stage_lsu;

   logic        clk;
   logic        rst;
   logic        m_valid;
   logic [31:0] m_alu_result;
   logic [31:0] m_write_data;
   logic [4:0]  m_rd;
   logic [2:0]  m_funct3;
   logic        m_mem_read;
   logic        m_mem_write;
   logic        m_reg_write;
   logic        m_result_src;
   logic        m_ready;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic        wb_exc;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        rdEn;
      logic        wrEn;
      logic        regw;
      logic        resSrc;
   } opT;

   logic [31:0] lastResult;
   logic [4:0]  lastRd;

   mem_stage_lsu #(
      .XLEN   (32),
      .REG_AW (5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .m_valid      (m_valid),
      .m_alu_result (m_alu_result),
      .m_write_data (m_write_data),
      .m_rd         (m_rd),
      .m_funct3     (m_funct3),
      .m_mem_read   (m_mem_read),
      .m_mem_write  (m_mem_write),
      .m_reg_write  (m_reg_write),
      .m_result_src (m_result_src),
      .m_ready      (m_ready),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_gnt     (dmem_gnt),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .wb_valid     (wb_valid),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_result    (wb_result),
      .wb_exc       (wb_exc)
   );

   // Free-running 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and reports tag/observed/expected on mismatch
   task automatic checkOutput(input string step, input string field,
                              input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s.%s observed=0x%08h expected=0x%08h", step, field, observed, expected);
      end
   endtask

   // Present one instruction on the EX/MEM side
   task automatic applyStimulus(input opT op);
      m_valid      = op.valid;
      m_alu_result = op.addr;
      m_write_data = op.wdata;
      m_rd         = op.rd;
      m_funct3     = op.f3;
      m_mem_read   = op.rdEn;
      m_mem_write  = op.wrEn;
      m_reg_write  = op.regw;
      m_result_src = op.resSrc;
   endtask

   // Reference load value: pick size bytes starting at the address lane,
   // interpret as unsigned or two's-complement, wrap to 32 bits
   function automatic logic [31:0] refLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [2:0] f3);
      longint unsigned sizeBits;
      longint unsigned raw;
      longint unsigned modulus;
      sizeBits = 64'd8 << f3[1:0];
      modulus  = 64'd1 << sizeBits;
      raw      = (longint'(rdata) >> (8 * (addr % 4))) % modulus;
      if (!f3[2] && raw >= modulus / 2) raw = raw + (64'd1 << 32) - modulus;
      return raw[31:0];
   endfunction

   // Reference store data: byte i of the bus carries store byte (i mod size)
   function automatic logic [31:0] refWdata(input logic [31:0] wdata, input int size);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r = r | (((wdata >> (8 * (i % size))) & 32'hFF) << (8 * i));
      return r;
   endfunction

   // Run one MEM instruction through to retirement with the given grant and
   // response delays, checking the bus and stall every cycle and WB afterwards
   task automatic runOp(input string name, input opT op, input int gntDelay,
                        input int rspDelay, input logic [31:0] rdata);
      int          size;
      bit          isMem;
      bit          isLoad;
      bit          fault;
      bit          reqCyc;
      int          doneCyc;
      logic [31:0] expBe;
      logic [31:0] expRes;
      size   = 1 << op.f3[1:0];
      isMem  = op.valid && (op.rdEn || op.wrEn);
      isLoad = isMem && op.rdEn && !op.wrEn;
      fault  = isMem && ((op.f3 == 3'b111) || (op.f3 == 3'b011) || (op.f3 == 3'b110) ||
                         ((op.addr % size) != 0));
      if (!isMem || fault) doneCyc = 0;
      else if (!isLoad)    doneCyc = gntDelay;
      else                 doneCyc = gntDelay + rspDelay;
      expBe = ((32'd1 << size) - 1) << (op.addr % 4);
      if (fault)       expRes = op.addr;
      else if (isLoad) expRes = refLoad(rdata, op.addr, op.f3);
      else             expRes = op.addr;
      applyStimulus(op);
      for (int k = 0; k <= doneCyc; k++) begin
         reqCyc = isMem && !fault && (k <= gntDelay);
         if (isMem && !fault) begin
            dmem_gnt    = (k == gntDelay);
            dmem_rvalid = (k < gntDelay) ? 1'($urandom) : (isLoad && k == gntDelay + rspDelay);
            dmem_rdata  = (k == doneCyc) ? rdata : $urandom;
         end else begin
            dmem_gnt    = 1'($urandom);
            dmem_rvalid = 1'($urandom);
            dmem_rdata  = $urandom;
         end
         @(negedge clk);
         checkOutput(name, "m_ready", 32'(m_ready), 32'(k == doneCyc && op.valid || !op.valid));
         checkOutput(name, "dmem_req", 32'(dmem_req), 32'(reqCyc));
         if (reqCyc) begin
            checkOutput(name, "dmem_addr", dmem_addr, op.addr & ~32'h3);
            checkOutput(name, "dmem_be", 32'(dmem_be), expBe);
            checkOutput(name, "dmem_we", 32'(dmem_we), 32'(!isLoad));
            if (!isLoad) checkOutput(name, "dmem_wdata", dmem_wdata, refWdata(op.wdata, size));
         end
         @(posedge clk);
         #1;
      end
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      m_valid     = 1'b0;
      if (op.valid) begin
         checkOutput(name, "wb_valid", 32'(wb_valid), 32'd1);
         checkOutput(name, "wb_exc", 32'(wb_exc), 32'(fault));
         checkOutput(name, "wb_reg_write", 32'(wb_reg_write), 32'(op.regw && !fault));
         checkOutput(name, "wb_rd", 32'(wb_rd), 32'(op.rd));
         checkOutput(name, "wb_result", wb_result, expRes);
         lastResult = expRes;
         lastRd     = op.rd;
      end else begin
         checkOutput(name, "wb_valid", 32'(wb_valid), 32'd0);
         checkOutput(name, "wb_result_hold", wb_result, lastResult);
      end
   endtask

   // One empty MEM slot: WB must not pulse and must keep its payload
   task automatic bubble(input string name);
      m_valid     = 1'b0;
      dmem_gnt    = 1'($urandom);
      dmem_rvalid = 1'($urandom);
      dmem_rdata  = $urandom;
      @(posedge clk);
      #1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      checkOutput(name, "wb_valid", 32'(wb_valid), 32'd0);
      checkOutput(name, "wb_result_hold", wb_result, lastResult);
      checkOutput(name, "wb_rd_hold", 32'(wb_rd), 32'(lastRd));
   endtask

   function automatic opT mkOp(input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit load, input bit store,
                               input logic [4:0] rd);
      opT o;
      o.valid  = 1'b1;
      o.addr   = addr;
      o.wdata  = wdata;
      o.rd     = rd;
      o.f3     = f3;
      o.rdEn   = load;
      o.wrEn   = store;
      o.regw   = !store;
      o.resSrc = load;
      return o;
   endfunction

   // Directed scenarios followed by a randomized instruction stream
   initial begin
      opT  op;
      int  kind;
      rst         = 1'b1;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = '0;
      lastResult  = '0;
      lastRd      = '0;
      applyStimulus('0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", "dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("reset", "wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("reset", "wb_reg_write", 32'(wb_reg_write), 32'd0);
      checkOutput("reset", "wb_exc", 32'(wb_exc), 32'd0);
      checkOutput("reset", "wb_rd", 32'(wb_rd), 32'd0);
      checkOutput("reset", "wb_result", wb_result, 32'd0);
      rst = 1'b0;

      runOp("sw", mkOp(3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 5'd3), 0, 1, 32'd0);
      runOp("sb", mkOp(3'b000, 32'h103, 32'h123456A5, 0, 1, 5'd4), 0, 1, 32'd0);
      runOp("sh", mkOp(3'b001, 32'h102, 32'h0000BEEF, 0, 1, 5'd5), 1, 1, 32'd0);
      runOp("lb", mkOp(3'b000, 32'h101, 32'd0, 1, 0, 5'd6), 0, 1, 32'h0000800F);
      checkOutput("lb", "const", wb_result, 32'hFFFFFF80);
      runOp("lbu", mkOp(3'b100, 32'h101, 32'd0, 1, 0, 5'd7), 0, 1, 32'h0000800F);
      checkOutput("lbu", "const", wb_result, 32'h00000080);
      runOp("lhu", mkOp(3'b101, 32'h102, 32'd0, 1, 0, 5'd8), 0, 2, 32'h80011234);
      checkOutput("lhu", "const", wb_result, 32'h00008001);
      runOp("lwMis", mkOp(3'b010, 32'h102, 32'd0, 1, 0, 5'd9), 0, 1, 32'd0);
      runOp("lwSlow", mkOp(3'b010, 32'h104, 32'd0, 1, 0, 5'd10), 3, 2, 32'hCAFEF00D);
      bubble("afterSlow");

      $display("[TB] reset during outstanding load");
      applyStimulus(mkOp(3'b010, 32'h108, 32'd0, 1, 0, 5'd11));
      dmem_gnt = 1'b1;
      @(negedge clk);
      checkOutput("rstMid", "dmem_req", 32'(dmem_req), 32'd1);
      @(posedge clk);
      #1;
      dmem_gnt = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst         = 1'b0;
      m_valid     = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h55AA55AA;
      @(negedge clk);
      checkOutput("rstMid", "dmem_req_idle", 32'(dmem_req), 32'd0);
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b0;
      checkOutput("rstMid", "wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("rstMid", "wb_result", wb_result, 32'd0);
      checkOutput("rstMid", "wb_rd", 32'(wb_rd), 32'd0);
      checkOutput("rstMid", "wb_reg_write", 32'(wb_reg_write), 32'd0);
      lastResult = '0;
      lastRd     = '0;
      runOp("afterRst", mkOp(3'b000, 32'h10C, 32'd0, 0, 0, 5'd12), 0, 1, 32'd0);

      $display("[TB] randomized instruction stream");
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 3);
         op   = mkOp(3'($urandom), 32'h100 + 32'($urandom_range(0, 15)), $urandom,
                     kind == 1, kind == 2, 5'($urandom));
         if (kind == 0) begin
            op.regw   = 1'($urandom);
            op.resSrc = 1'b0;
         end
         if (kind == 3) op.valid = 1'b0;
         runOp($sformatf("rnd%0d", n), op, $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
         if ($urandom_range(0, 4) == 0) bubble($sformatf("rndBubble%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
